// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes,
// controller states and the latched request bundle.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] MA_IDLE   = 2'd0;
  localparam logic [1:0] MA_ACCESS = 2'd1;
  localparam logic [1:0] MA_RESP   = 2'd2;
  localparam logic [1:0] MA_ERROR  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  op;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ma_req_t;

endpackage

// File: rtl/mem_align_check.sv
// Alignment checker: flags a misaligned or unknown-size access.
// Ports: i_op (size), i_addr (addr[1:0]), o_misaligned.
module mem_align_check
  import mem_access_unit_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [1:0] i_addr,
  output logic       o_misaligned
);

  always_comb begin
    o_misaligned = 1'b1;
    unique case (1'b1)
      (i_op == MEM_BYTE): o_misaligned = 1'b0;
      (i_op == MEM_HALF): o_misaligned = i_addr[0];
      (i_op == MEM_WORD): o_misaligned = |i_addr;
      default:            o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access controller with MDR and counters.
// Ports: req_* handshake in, resp_* out, dm_* to data memory,
// ld/st/err_count saturating statistics.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_op,
  input  logic             req_ext,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             dm_wr,
  output logic             dm_read,
  output logic [1:0]       dm_op,
  output logic             dm_ext,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count,
  output logic [CNT_W-1:0] err_count
);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  ma_req_t          r_req;
  logic [31:0]      r_mdr;
  logic [CNT_W-1:0] r_ld_cnt;
  logic [CNT_W-1:0] r_st_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_misaligned;
  logic             w_accept;

  mem_align_check u_align (
    .i_op         (req_op),
    .i_addr       (req_addr[1:0]),
    .o_misaligned (w_misaligned)
  );

  assign w_accept = req_valid && (r_state == MA_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MA_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MA_IDLE: begin
        if (w_accept)
          w_next = w_misaligned ? MA_ERROR : MA_ACCESS;
      end
      MA_ACCESS: w_next = MA_RESP;
      MA_RESP:   w_next = MA_IDLE;
      MA_ERROR:  w_next = MA_IDLE;
      default:   w_next = MA_IDLE;
    endcase
  end

  // Strobes are pure state decodes so reset kills them at once.
  always_comb begin
    req_ready  = (r_state == MA_IDLE);
    dm_wr      = (r_state == MA_ACCESS) && r_req.we;
    dm_read    = (r_state == MA_ACCESS) && !r_req.we;
    resp_valid = (r_state == MA_RESP) || (r_state == MA_ERROR);
    resp_err   = (r_state == MA_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.we    <= req_we;
      r_req.op    <= req_op;
      r_req.ext   <= req_ext;
      r_req.addr  <= req_addr;
      r_req.wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_mdr <= '0;
    else if ((r_state == MA_ACCESS) && !r_req.we)
      r_mdr <= dm_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_cnt  <= '0;
      r_st_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_state == MA_RESP) begin
        if (r_req.we) begin
          if (r_st_cnt != '1)
            r_st_cnt <= r_st_cnt + CNT_W'(1);
        end else begin
          if (r_ld_cnt != '1)
            r_ld_cnt <= r_ld_cnt + CNT_W'(1);
        end
      end
      if ((r_state == MA_ERROR) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign dm_op      = r_req.op;
  assign dm_ext     = r_req.ext;
  assign dm_addr    = r_req.addr;
  assign dm_din     = r_req.wdata;
  assign resp_rdata = r_mdr;
  assign ld_count   = r_ld_cnt;
  assign st_count   = r_st_cnt;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a little-endian
// byte-array data memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_ext;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_wr, dm_read, dm_ext;
  logic [1:0]  dm_op;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic [15:0] ld_count, st_count, err_count;

  logic        s_valid, s_ready, s_we, s_ext;
  logic [1:0]  s_op;
  logic [31:0] s_addr, s_wdata;
  logic        s_rv, s_re;
  logic [31:0] s_rdata;
  logic        s_wr, s_rd, s_dext;
  logic [1:0]  s_dop;
  logic [31:0] s_daddr, s_ddin;
  logic [1:0]  s_ld, s_st, s_err;

  mem_access_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op), .req_ext(req_ext),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .dm_wr(dm_wr), .dm_read(dm_read), .dm_op(dm_op),
    .dm_ext(dm_ext), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout),
    .ld_count(ld_count), .st_count(st_count),
    .err_count(err_count)
  );

  mem_access_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_we(s_we), .req_op(s_op), .req_ext(s_ext),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .resp_valid(s_rv), .resp_err(s_re),
    .resp_rdata(s_rdata),
    .dm_wr(s_wr), .dm_read(s_rd), .dm_op(s_dop),
    .dm_ext(s_dext), .dm_addr(s_daddr), .dm_din(s_ddin),
    .dm_dout(32'h0),
    .ld_count(s_ld), .st_count(s_st), .err_count(s_err)
  );

  logic [7:0]  mem [0:255];
  logic [7:0]  ra;
  logic [31:0] rw;
  int          wr_cycles = 0;

  always @(negedge clk) begin
    if (dm_wr) begin
      wr_cycles <= wr_cycles + 1;
      mem[dm_addr[7:0]] <= dm_din[7:0];
      if (dm_op != MEM_BYTE)
        mem[dm_addr[7:0] + 8'd1] <= dm_din[15:8];
      if (dm_op == MEM_WORD) begin
        mem[dm_addr[7:0] + 8'd2] <= dm_din[23:16];
        mem[dm_addr[7:0] + 8'd3] <= dm_din[31:24];
      end
    end
  end

  assign ra = dm_addr[7:0];

  always_comb begin
    rw = {mem[ra + 8'd3], mem[ra + 8'd2],
          mem[ra + 8'd1], mem[ra]};
    dm_dout = 32'h0;
    case (dm_op)
      MEM_BYTE: dm_dout = dm_ext ? {{24{rw[7]}}, rw[7:0]}
                                 : {24'h0, rw[7:0]};
      MEM_HALF: dm_dout = dm_ext ? {{16{rw[15]}}, rw[15:0]}
                                 : {16'h0, rw[15:0]};
      MEM_WORD: dm_dout = rw;
      default:  dm_dout = 32'h0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] op,
                        input logic ext, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err,
                        input string tag);
    int w0;
    w0 = wr_cycles;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_ext   = ext;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_err) begin
      chk({tag, "_acc_wr"}, 32'(dm_wr), 32'(we));
      chk({tag, "_acc_rd"}, 32'(dm_read), 32'(!we));
      chk({tag, "_acc_addr"}, dm_addr, addr);
      chk({tag, "_acc_rv"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
      chk({tag, "_re"}, 32'(resp_err), 32'd0);
    end else begin
      chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
      chk({tag, "_re"}, 32'(resp_err), 32'd1);
      chk({tag, "_err_wr"}, 32'(dm_wr), 32'd0);
      chk({tag, "_err_rd"}, 32'(dm_read), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_rv"}, 32'(resp_valid), 32'd0);
    chk({tag, "_wrcnt"}, 32'(wr_cycles - w0),
        (we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int w0;
    int cyc;
    logic found;
    logic [1:0] bad_op;
    req_valid = 1'b0; req_we = 1'b0; req_op = MEM_BYTE;
    req_ext = 1'b0; req_addr = '0; req_wdata = '0;
    s_valid = 1'b0; s_we = 1'b0; s_op = MEM_BYTE;
    s_ext = 1'b0; s_addr = '0; s_wdata = '0;
    bad_op = 2'b11;

    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_re", 32'(resp_err), 32'd0);
    chk("rst_wr", 32'(dm_wr), 32'd0);
    chk("rst_rd", 32'(dm_read), 32'd0);
    chk("rst_mdr", resp_rdata, 32'h0);
    chk("rst_ld", 32'(ld_count), 32'd0);
    chk("rst_st", 32'(st_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, MEM_WORD, 1'b0, BASE + 32'h10, 32'hDEADBEEF,
           1'b0, "st_w");
    do_req(1'b0, MEM_WORD, 1'b0, BASE + 32'h10, 32'h0,
           1'b0, "ld_w");
    chk("ld_w_data", resp_rdata, 32'hDEADBEEF);
    chk("cnt_st1", 32'(st_count), 32'd1);
    chk("cnt_ld1", 32'(ld_count), 32'd1);

    do_req(1'b0, MEM_BYTE, 1'b1, BASE + 32'h13, 32'h0,
           1'b0, "ld_bs");
    chk("ld_bs_data", resp_rdata, 32'hFFFFFFDE);
    do_req(1'b0, MEM_HALF, 1'b0, BASE + 32'h12, 32'h0,
           1'b0, "ld_hz");
    chk("ld_hz_data", resp_rdata, 32'h0000DEAD);
    do_req(1'b0, MEM_BYTE, 1'b0, BASE + 32'h10, 32'h0,
           1'b0, "ld_bz");
    chk("ld_bz_data", resp_rdata, 32'h000000EF);

    do_req(1'b1, MEM_HALF, 1'b0, BASE + 32'h11, 32'h1234,
           1'b1, "mis_st");
    chk("mis_err_cnt", 32'(err_count), 32'd1);
    chk("mis_mdr", resp_rdata, 32'h000000EF);
    chk("mis_st_cnt", 32'(st_count), 32'd1);
    do_req(1'b0, MEM_WORD, 1'b0, BASE + 32'h10, 32'h0,
           1'b0, "ld_after");
    chk("ld_after_data", resp_rdata, 32'hDEADBEEF);

    do_req(1'b0, bad_op, 1'b0, BASE + 32'h10, 32'h0,
           1'b1, "bad_op");
    chk("bad_op_err_cnt", 32'(err_count), 32'd2);
    chk("bad_op_mdr", resp_rdata, 32'hDEADBEEF);

    w0 = wr_cycles;
    req_valid = 1'b1; req_we = 1'b1; req_op = MEM_WORD;
    req_ext = 1'b0; req_addr = BASE + 32'h20;
    req_wdata = 32'h11223344;
    @(posedge clk); #1;
    chk("b2b_a_wr", 32'(dm_wr), 32'd1);
    chk("b2b_a_addr", dm_addr, BASE + 32'h20);
    req_addr = BASE + 32'h24;
    req_wdata = 32'h55667788;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (dm_wr === 1'b1 && dm_addr === BASE + 32'h24)
        found = 1'b1;
    end
    req_valid = 1'b0;
    chk("b2b_gap", 32'(cyc), 32'd3);
    @(posedge clk); #1;
    chk("b2b_b_rv", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    chk("b2b_wrcnt", 32'(wr_cycles - w0), 32'd2);
    chk("b2b_st_cnt", 32'(st_count), 32'd3);
    do_req(1'b0, MEM_WORD, 1'b0, BASE + 32'h20, 32'h0,
           1'b0, "ld_a");
    chk("ld_a_data", resp_rdata, 32'h11223344);
    do_req(1'b0, MEM_WORD, 1'b0, BASE + 32'h24, 32'h0,
           1'b0, "ld_b");
    chk("ld_b_data", resp_rdata, 32'h55667788);
    chk("pre_rst_ld", 32'(ld_count), 32'd7);
    chk("pre_rst_st", 32'(st_count), 32'd3);
    chk("pre_rst_err", 32'(err_count), 32'd2);

    req_valid = 1'b1; req_we = 1'b1; req_op = MEM_WORD;
    req_addr = BASE + 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wr_before", 32'(dm_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_wr_drop", 32'(dm_wr), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid_rv_rst", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rv", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_ld", 32'(ld_count), 32'd0);
    chk("post_st", 32'(st_count), 32'd0);
    chk("post_err", 32'(err_count), 32'd0);
    chk("post_mdr", resp_rdata, 32'h0);

    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_we = i[0];
      s_op = MEM_WORD;
      s_addr = BASE + 32'h2;
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("sat_rv", 32'(s_rv), 32'd1);
      chk("sat_re", 32'(s_re), 32'd1);
      chk("sat_wr", 32'(s_wr), 32'd0);
      @(posedge clk); #1;
      chk("sat_cnt", 32'(s_err), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("sat_ld", 32'(s_ld), 32'd0);
    chk("sat_st", 32'(s_st), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
